// File: rtl/arbitro_calculo_pkg.sv
// Package: arbitro_calculo_pkg
// Purpose: shared definitions for the arbitro_calculo slice: FSM state
//          encoding and the default operand widths of the shared datapath.
// Contents:
//   DEF_W   default width of A, B, C and resultado
//   DEF_KW  default width of K
//   state_t arbiter FSM states (IDLE/START/WAIT/RESP)
package arbitro_calculo_pkg;

  localparam int DEF_W  = 16;
  localparam int DEF_KW = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/arbitro_calculo_rr_arbitro.sv
// Module: rr_arbitro
// Purpose: combinational round-robin pick. The search begins at ptr+1 and
//          wraps, so the requester granted last has the lowest priority.
// Ports:
//   req    in  N_REQ  pending requests
//   ptr    in  ID_W   index of the previously granted requester
//   grant  out N_REQ  one-hot winner (all zero when req is zero)
//   idx    out ID_W   encoded winner index
//   any    out 1      at least one request is pending
module rr_arbitro
  import arbitro_calculo_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  idx,
  output logic             any
);

  int cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = 0;
    // k = N_REQ visits ptr itself last, so a lone requester is re-granted.
    for (int k = 1; k <= N_REQ; k++) begin
      cand = (int'(ptr) + k) % N_REQ;
      if (!any && req[cand]) begin
        any         = 1'b1;
        grant[cand] = 1'b1;
        idx         = ID_W'(cand);
      end
    end
  end

endmodule

// File: rtl/arbitro_calculo.sv
// Module: arbitro_calculo
// Purpose: shares one projetoFinal datapath between N_REQ requesters.
//          Round-robin grant, latches the winner's operands, pulses
//          dp_inicio once, waits for dp_pronto and returns the result
//          tagged with the requester id.
// Optional feature: define ARB_TIMEOUT_EN to abort a job that spends
//          TIMEOUT cycles in WAIT without dp_pronto (resp_erro=1, result 0,
//          dp_rst pulsed during RESP). Without it WAIT waits forever,
//          resp_erro is 0 and dp_rst follows rst.
// Ports:
//   clk, rst                     clock (rising edge), synchronous active-high reset
//   req_valid/req_ready          per-requester handshake
//   req_a/b/c, req_k             flattened operands, requester i at [i*W +: W] / [i*KW +: KW]
//   dp_a/b/c, dp_k, dp_inicio    to the datapath
//   dp_pronto, dp_resultado      from the datapath
//   dp_rst                       datapath reset
//   resp_valid/id/resultado/erro response strobe and payload
//   ocupado                      state != IDLE
//   dbg_state                    current FSM state
// Handshake: request i is taken in the cycle req_valid[i] & req_ready[i];
//   req_ready is one-hot in IDLE and zero in all other states, and resp_valid
//   is a single-cycle strobe with no back-pressure.
module arbitro_calculo
  import arbitro_calculo_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int W       = DEF_W,
  parameter int KW      = DEF_KW,
  parameter int TIMEOUT = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [W*N_REQ-1:0]         req_a,
  input  logic [W*N_REQ-1:0]         req_b,
  input  logic [W*N_REQ-1:0]         req_c,
  input  logic [KW*N_REQ-1:0]        req_k,
  output logic [N_REQ-1:0]           req_ready,
  output logic [W-1:0]               dp_a,
  output logic [W-1:0]               dp_b,
  output logic [W-1:0]               dp_c,
  output logic [KW-1:0]              dp_k,
  output logic                       dp_inicio,
  input  logic                       dp_pronto,
  input  logic [W-1:0]               dp_resultado,
  output logic                       dp_rst,
  output logic                       resp_valid,
  output logic [$clog2(N_REQ)-1:0]   resp_id,
  output logic [W-1:0]               resp_resultado,
  output logic                       resp_erro,
  output logic                       ocupado,
  output state_t                     dbg_state
);

  localparam int ID_W = $clog2(N_REQ);

  if (N_REQ < 2 || TIMEOUT < 1) begin : g_bad_cfg
    $error("arbitro_calculo: N_REQ must be >= 2 and TIMEOUT >= 1");
  end

  state_t            state;
  logic [ID_W-1:0]   ptr;
  logic [ID_W-1:0]   id;
  logic [N_REQ-1:0]  grant;
  logic [ID_W-1:0]   gidx;
  logic              gany;

  rr_arbitro #(.N_REQ(N_REQ), .ID_W(ID_W)) u_rr (
    .req   (req_valid),
    .ptr   (ptr),
    .grant (grant),
    .idx   (gidx),
    .any   (gany)
  );

  assign req_ready  = (state == S_IDLE) ? grant : '0;
  assign dp_inicio  = (state == S_START);
  assign resp_valid = (state == S_RESP);
  assign ocupado    = (state != S_IDLE);
  assign dbg_state  = state;

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt;
  logic             erro_q;

  assign resp_erro = erro_q;
  // Abort pulse is aligned with the RESP cycle of an aborted job.
  assign dp_rst    = rst | ((state == S_RESP) & erro_q);
`else
  assign resp_erro = 1'b0;
  assign dp_rst    = rst;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      ptr            <= ID_W'(N_REQ - 1);
      id             <= '0;
      dp_a           <= '0;
      dp_b           <= '0;
      dp_c           <= '0;
      dp_k           <= '0;
      resp_id        <= '0;
      resp_resultado <= '0;
`ifdef ARB_TIMEOUT_EN
      cnt            <= '0;
      erro_q         <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (gany) begin
            // Operands are frozen here; later req_* changes cannot reach the job.
            dp_a  <= req_a[int'(gidx)*W +: W];
            dp_b  <= req_b[int'(gidx)*W +: W];
            dp_c  <= req_c[int'(gidx)*W +: W];
            dp_k  <= req_k[int'(gidx)*KW +: KW];
            id    <= gidx;
            ptr   <= gidx;
            state <= S_START;
          end
        end
        S_START: begin
`ifdef ARB_TIMEOUT_EN
          cnt   <= '0;
`endif
          state <= S_WAIT;
        end
        S_WAIT: begin
          // dp_pronto is tested first so it wins over a coinciding timeout.
          if (dp_pronto) begin
            resp_resultado <= dp_resultado;
            resp_id        <= id;
            state          <= S_RESP;
`ifdef ARB_TIMEOUT_EN
            erro_q         <= 1'b0;
          end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            resp_resultado <= '0;
            resp_id        <= id;
            erro_q         <= 1'b1;
            state          <= S_RESP;
          end else begin
            cnt <= cnt + 1'b1;
`endif
          end
        end
        S_RESP: begin
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_arbitro_calculo.sv
// Testbench: tb_arbitro_calculo
// Purpose: directed tests for arbitro_calculo with a datapath stub
//          (resultado = A+B+C+K, dp_pronto L cycles after dp_inicio).
//          A behavioural model (accept times, round-robin order, expected
//          response queue) is compared with the DUT on every cycle, and
//          literal expectations pin each directed scenario.
//          Scenarios 5 and 6 are built only when ARB_TIMEOUT_EN is defined.
module tb_arbitro_calculo;
  localparam int N_REQ   = 4;
  localparam int W       = 16;
  localparam int KW      = 8;
  localparam int TIMEOUT = 64;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [N_REQ-1:0]    req_valid = '0;
  logic [W*N_REQ-1:0]  req_a = '0, req_b = '0, req_c = '0;
  logic [KW*N_REQ-1:0] req_k = '0;
  logic [N_REQ-1:0]    req_ready;
  logic [W-1:0]        dp_a, dp_b, dp_c;
  logic [KW-1:0]       dp_k;
  logic                dp_inicio;
  logic                dp_pronto = 1'b0;
  logic [W-1:0]        dp_resultado = '0;
  logic                dp_rst;
  logic                resp_valid;
  logic [1:0]          resp_id;
  logic [W-1:0]        resp_resultado;
  logic                resp_erro;
  logic                ocupado;
  logic [1:0]          dbg_state;

  arbitro_calculo #(.N_REQ(N_REQ), .W(W), .KW(KW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_c(req_c), .req_k(req_k),
    .req_ready(req_ready),
    .dp_a(dp_a), .dp_b(dp_b), .dp_c(dp_c), .dp_k(dp_k), .dp_inicio(dp_inicio),
    .dp_pronto(dp_pronto), .dp_resultado(dp_resultado), .dp_rst(dp_rst),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_resultado(resp_resultado),
    .resp_erro(resp_erro), .ocupado(ocupado), .dbg_state(dbg_state)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (time %0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- datapath stub ----------------
  int         stub_L     = 5;
  bit         stub_never = 1'b0;
  int         rem        = 0;
  logic [W-1:0] stub_sum = '0;

  always @(posedge clk) begin
    dp_pronto <= 1'b0;
    if (rst) begin
      rem = 0;
    end else begin
      if (dp_inicio) begin
        rem      = stub_L;
        stub_sum = dp_a + dp_b + dp_c + {{(W-KW){1'b0}}, dp_k};
      end
      if (rem > 0) begin
        rem--;
        if (rem == 0 && !stub_never) begin
          dp_pronto    <= 1'b1;
          dp_resultado <= stub_sum;
        end
      end
    end
  end

  // ---------------- model + scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int grant_log[$];
  int acc_cyc_log[$];
  int inicio_log[$];
  int resp_cyc_log[$];
  int resp_id_log[$];
  int resp_res_log[$];
  int resp_err_log[$];
  int dprst_log[$];
  int ready_cnt = 0;

  int           cyc = 0;
  bit           m_busy = 1'b0;
  int           m_last = N_REQ - 1;
  int           m_tacc, m_tresp, m_id;
  bit           m_err;
  logic [W-1:0] m_a, m_b, m_c;
  logic [KW-1:0] m_k;
  logic [W-1:0] m_last_res = '0;
  int           m_last_id = 0;
  bit           m_last_err = 1'b0;

  function automatic int rr_pick(input logic [N_REQ-1:0] v, input int last);
    for (int k = 1; k <= N_REQ; k++)
      if (v[(last + k) % N_REQ]) return (last + k) % N_REQ;
    return -1;
  endfunction

  always @(negedge clk) begin
    int w;
    logic [W-1:0] sum;
    bit at_resp;
    cyc++;
    if (rst) begin
      m_busy     = 1'b0;
      m_last     = N_REQ - 1;
      m_last_res = '0;
      m_last_id  = 0;
      m_last_err = 1'b0;
      exp_q.delete();
    end else begin
      if (req_ready != '0) ready_cnt++;
      if (dp_inicio) inicio_log.push_back(cyc);
      if (dp_rst) dprst_log.push_back(cyc);
      if (resp_valid) begin
        resp_cyc_log.push_back(cyc);
        resp_id_log.push_back(int'(resp_id));
        resp_res_log.push_back(int'(resp_resultado));
        resp_err_log.push_back(int'(resp_erro));
      end
      at_resp = m_busy && (cyc == m_tresp);
      if (at_resp) begin
        if (exp_q.size() > 0) m_last_res = exp_q.pop_front();
        else                  m_last_res = 'x;
        m_last_id  = m_id;
        m_last_err = m_err;
      end
      chk("ocupado", 32'(ocupado), 32'(m_busy));
      chk("resp_valid", 32'(resp_valid), 32'(at_resp));
      chk("dp_inicio", 32'(dp_inicio), 32'(m_busy && cyc == m_tacc + 1));
      chk("dp_rst", 32'(dp_rst), 32'(at_resp && m_err));
      chk("resp_id", 32'(resp_id), 32'(m_last_id));
      chk("resp_resultado", 32'(resp_resultado), 32'(m_last_res));
      chk("resp_erro", 32'(resp_erro), 32'(m_last_err));
      if (m_busy) begin
        chk("req_ready_busy", 32'(req_ready), 32'(0));
        chk("dp_a", 32'(dp_a), 32'(m_a));
        chk("dp_b", 32'(dp_b), 32'(m_b));
        chk("dp_c", 32'(dp_c), 32'(m_c));
        chk("dp_k", 32'(dp_k), 32'(m_k));
        if (at_resp) m_busy = 1'b0;
      end else begin
        w = rr_pick(req_valid, m_last);
        chk("req_ready_idle", 32'(req_ready), (w >= 0) ? (32'd1 << w) : 32'd0);
        if (w >= 0) begin
          m_busy = 1'b1;
          m_tacc = cyc;
          m_id   = w;
          m_last = w;
          m_a    = req_a[w*W +: W];
          m_b    = req_b[w*W +: W];
          m_c    = req_c[w*W +: W];
          m_k    = req_k[w*KW +: KW];
          sum    = m_a + m_b + m_c + W'(m_k);
          m_err  = 1'b0;
          m_tresp = cyc + 2 + stub_L;
`ifdef ARB_TIMEOUT_EN
          if (stub_never || stub_L > TIMEOUT) begin
            m_err   = 1'b1;
            m_tresp = cyc + 2 + TIMEOUT;
          end
`endif
          exp_q.push_back(m_err ? '0 : sum);
          grant_log.push_back(w);
          acc_cyc_log.push_back(cyc);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] c, input logic [KW-1:0] k);
    req_a[i*W +: W]   = a;
    req_b[i*W +: W]   = b;
    req_c[i*W +: W]   = c;
    req_k[i*KW +: KW] = k;
  endtask

  task automatic wait_grants(input int n, input int budget);
    int k = 0;
    while (grant_log.size() < n && k < budget) begin
      tick();
      k++;
    end
    chk("grant_wait", 32'(grant_log.size() >= n), 32'd1);
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while (m_busy && k < budget) begin
      tick();
      k++;
    end
    tick();
    chk("idle_wait", 32'(m_busy), 32'd0);
  endtask

  // ---------------- directed tests ----------------
  initial begin
    int gb, rb, ib, rc0;
    int order[5] = '{0, 1, 2, 3, 0};

    repeat (2) tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ocupado", 32'(ocupado), 32'd0);
    chk("rst_dp_a", 32'(dp_a), 32'd0);
    chk("rst_resp_id", 32'(resp_id), 32'd0);
    chk("rst_resp_res", 32'(resp_resultado), 32'd0);
    chk("rst_dp_rst", 32'(dp_rst), 32'd0);
    tick();

    // 1: requester 1, 3+4+6+8 = 21, L=5
    stub_L = 5;
    gb = grant_log.size(); rb = resp_cyc_log.size(); ib = inicio_log.size(); rc0 = ready_cnt;
    set_req(1, 16'd3, 16'd4, 16'd6, 8'd8);
    req_valid = 4'b0010;
    wait_grants(gb + 1, 20);
    req_valid = '0;
    wait_idle(50);
    chk("t1_grant", 32'(grant_log[gb]), 32'd1);
    chk("t1_ready_cycles", 32'(ready_cnt - rc0), 32'd1);
    chk("t1_inicio_lat", 32'(inicio_log[ib] - acc_cyc_log[gb]), 32'd1);
    chk("t1_resp_lat", 32'(resp_cyc_log[rb] - acc_cyc_log[gb]), 32'd7);
    chk("t1_resp_id", 32'(resp_id_log[rb]), 32'd1);
    chk("t1_resp_res", 32'(resp_res_log[rb]), 32'd21);

    // 2: all requesters valid continuously -> 0,1,2,3,0
    do_reset();
    stub_L = 2;
    gb = grant_log.size();
    for (int i = 0; i < N_REQ; i++)
      set_req(i, W'(i * 10 + 1), W'(i + 2), 16'd7, KW'(i));
    req_valid = 4'b1111;
    wait_grants(gb + 5, 100);
    req_valid = '0;
    wait_idle(50);
    for (int i = 0; i < 5; i++) chk("t2_order", 32'(grant_log[gb + i]), 32'(order[i]));
    chk("t2_spacing", 32'(acc_cyc_log[gb + 1] - acc_cyc_log[gb]), 32'd5);

    // 3: requester 2 changes A after acceptance
    stub_L = 4;
    gb = grant_log.size(); rb = resp_cyc_log.size(); ib = inicio_log.size();
    set_req(2, 16'd3, 16'd4, 16'd6, 8'd8);
    req_valid = 4'b0100;
    wait_grants(gb + 1, 20);
    req_valid = '0;
    set_req(2, 16'd100, 16'd4, 16'd6, 8'd8);
    tick();
    set_req(2, 16'd100, 16'd50, 16'd6, 8'd8);
    wait_idle(50);
    chk("t3_grant", 32'(grant_log[gb]), 32'd2);
    chk("t3_resp_res", 32'(resp_res_log[rb]), 32'd21);
    chk("t3_resp_id", 32'(resp_id_log[rb]), 32'd2);
    chk("t3_inicio_count", 32'(inicio_log.size() - ib), 32'd1);

    // 4: reset during WAIT, requester 3 keeps req_valid
    stub_L = 10;
    gb = grant_log.size(); rb = resp_cyc_log.size();
    set_req(3, 16'd5, 16'd5, 16'd5, 8'd5);
    req_valid = 4'b1000;
    wait_grants(gb + 1, 20);
    repeat (3) tick();
    chk("t4_in_wait", 32'(dbg_state), 32'd2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("t4_ocupado", 32'(ocupado), 32'd0);
    chk("t4_resp_valid", 32'(resp_valid), 32'd0);
    chk("t4_regrant", 32'(req_ready), 32'b1000);
    wait_grants(gb + 2, 10);
    req_valid = '0;
    wait_idle(50);
    chk("t4_grant", 32'(grant_log[gb + 1]), 32'd3);
    chk("t4_resp_count", 32'(resp_cyc_log.size() - rb), 32'd1);
    chk("t4_resp_res", 32'(resp_res_log[rb]), 32'd20);

`ifdef ARB_TIMEOUT_EN
    // 5: datapath never answers -> abort 65 cycles after dp_inicio
    stub_never = 1'b1;
    stub_L = 5;
    gb = grant_log.size(); rb = resp_cyc_log.size(); ib = inicio_log.size();
    set_req(0, 16'd1, 16'd1, 16'd1, 8'd1);
    req_valid = 4'b0001;
    wait_grants(gb + 1, 20);
    req_valid = '0;
    wait_idle(200);
    stub_never = 1'b0;
    chk("t5_erro", 32'(resp_err_log[rb]), 32'd1);
    chk("t5_res", 32'(resp_res_log[rb]), 32'd0);
    chk("t5_lat", 32'(resp_cyc_log[rb] - inicio_log[ib]), 32'd65);
    chk("t5_dp_rst", 32'(dprst_log[dprst_log.size() - 1]), 32'(resp_cyc_log[rb]));

    // 6: dp_pronto on the timeout cycle -> normal response
    stub_L = TIMEOUT;
    rb = resp_cyc_log.size(); gb = grant_log.size();
    set_req(1, 16'd1, 16'd2, 16'd3, 8'd4);
    req_valid = 4'b0010;
    wait_grants(gb + 1, 20);
    req_valid = '0;
    wait_idle(200);
    chk("t6_erro", 32'(resp_err_log[rb]), 32'd0);
    chk("t6_res", 32'(resp_res_log[rb]), 32'd10);
`endif

    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
